// File: rtl/uart_tx_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_queue_if : byte-write handshake and serial status bundle  |
// | Rev 1.0                                                           |
// +--------------------------------------------------------------------+
interface uart_tx_queue_if;
    logic       dataWriteEnable;
    logic [7:0] dataWrite;
    logic       dataWriteAck;
    logic       txFull;
    logic [2:0] txCount;
    logic       txBusy;
    logic       tx;

    modport master (
        output dataWriteEnable, dataWrite,
        input  dataWriteAck, txFull, txCount, txBusy, tx
    );

    modport slave (
        input  dataWriteEnable, dataWrite,
        output dataWriteAck, txFull, txCount, txBusy, tx
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_queue : 4-entry byte queue feeding an 8N1 UART serializer |
// | Rev 1.0                                                           |
// +--------------------------------------------------------------------+
module uart_tx_queue #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_queue_if.slave  bus
);

    localparam logic [15:0] C_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  C_DEPTH    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic        ack_q;
    logic        full_q;
    logic        busy_q;
    logic [7:0]  mem_q [4];

    logic w_accept;
    logic w_pop;
    logic w_bit_done;
    logic w_have_data;

    // Acceptance looks only at the registered count, so a pop at the same edge cannot free a slot.
    assign w_accept    = bus.dataWriteEnable && (count_q != C_DEPTH);
    assign w_bit_done  = (timer_q == C_BIT_LAST);
    assign w_have_data = (count_q != 3'd0);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = 16'd0;
                if (w_have_data) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[head_q];
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    timer_d   = 16'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    timer_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    timer_d = 16'd0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (w_have_data) begin
                        w_pop   = 1'b1;
                        shift_d = mem_q[head_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                timer_d = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        head_d  = head_q + {1'b0, w_pop};
        tail_d  = tail_q + {1'b0, w_accept};
        count_d = count_q + {2'b00, w_accept} - {2'b00, w_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            head_q    <= 2'd0;
            tail_q    <= 2'd0;
            count_q   <= 3'd0;
            ack_q     <= 1'b0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ack_q     <= w_accept;
            full_q    <= (count_d == C_DEPTH);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_accept && !reset) begin
            mem_q[tail_q] <= bus.dataWrite;
        end
    end

    assign bus.dataWriteAck = ack_q;
    assign bus.txFull       = full_q;
    assign bus.txCount      = count_q;
    assign bus.txBusy       = busy_q;
    assign bus.tx           = tx_q;

endmodule
`default_nettype wire
